// File: rtl/snes_pad_responder.sv
// snes_pad_responder: SNES pad model that answers the latch/pulse poll with a 16-bit serial frame.
// Pins are synchronized, edge-detected, and the frame {ID_BITS, ~buttons} is sent LSB first.
module snes_pad_responder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter logic [3:0] ID_BITS = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        latch,
  input  logic        pulse,
  input  logic [11:0] buttons,
  output logic        data,
  output logic        frame_done,
  output logic        active,
  output logic [7:0]  poll_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3;
  // [0] and [1] are the synchronizer stages, [2] is the edge register
  logic [2:0] latch_sync, pulse_sync;
  logic [1:0] state, nxt;
  logic [15:0] shreg;
  logic [4:0] bit_idx;
  logic [TW-1:0] tcnt;
  logic latch_rise, latch_fall, pulse_rise, any_edge, counting, timeout;
  assign latch_rise = latch_sync[1] & ~latch_sync[2];
  assign latch_fall = ~latch_sync[1] & latch_sync[2];
  assign pulse_rise = pulse_sync[1] & ~pulse_sync[2];
  assign any_edge = (latch_sync[1] ^ latch_sync[2]) | (pulse_sync[1] ^ pulse_sync[2]);
  assign counting = state == SHIFT || state == DONE;
  assign timeout = counting && !any_edge && tcnt == TLAST;
  // latch restart outranks everything, so a same-cycle pulse edge is dropped
  assign nxt = (latch_rise || (state == IDLE && latch_sync[1])) ? LOAD :
               (state == LOAD && latch_fall) ? SHIFT :
               timeout ? IDLE :
               (state == SHIFT && pulse_rise && bit_idx == 5'd15) ? DONE : state;
  assign data = state == IDLE ? 1'b1 : state == DONE ? 1'b0 : shreg[0];
  assign active = state == LOAD || state == SHIFT;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      latch_sync <= '0;
      pulse_sync <= '0;
      state <= IDLE;
      shreg <= 16'hFFFF;
      bit_idx <= '0;
      tcnt <= '0;
      frame_done <= 1'b0;
      poll_count <= '0;
    end else begin
      latch_sync <= {latch_sync[1:0], latch};
      pulse_sync <= {pulse_sync[1:0], pulse};
      state <= nxt;
      frame_done <= state == SHIFT && nxt == DONE;
      if (state == SHIFT && nxt == DONE) poll_count <= poll_count + 8'd1;
      tcnt <= (any_edge || !counting) ? '0 : tcnt == TLAST ? tcnt : tcnt + 1'b1;
      if (nxt == LOAD || state == LOAD) begin
        shreg <= {ID_BITS, ~buttons};
        bit_idx <= '0;
      end else if (state == SHIFT && pulse_rise) begin
        shreg <= {1'b0, shreg[15:1]};
        bit_idx <= bit_idx + 5'd1;
      end
    end
endmodule

// File: tb/tb_snes_pad_responder.sv
// tb_snes_pad_responder: randomized and directed polls checked every cycle against a frame-level pad model.
module tb_snes_pad_responder;
  localparam int T = 100;
  localparam logic [3:0] ID = 4'b1111;
  localparam int M_IDLE = 0, M_LOAD = 1, M_SHIFT = 2, M_DONE = 3;
  logic clk = 0, rst = 1, latch = 0, pulse = 0;
  logic [11:0] buttons = '0;
  logic data, frame_done, active;
  logic [7:0] poll_count;
  int total = 0, bad = 0;
  int m_st = M_IDLE, m_k = 0, m_q = 0, m_polls = 0, fd_cnt = 0, nframes = 0;
  logic m_done = 0, prev_data = 1;
  logic [15:0] m_frame = 16'hFFFF, stream = '0;
  logic [3:0] lh = '0, ph = '0;

  snes_pad_responder #(.TIMEOUT_CYCLES(T), .ID_BITS(ID)) dut (
    .clk(clk), .rst(rst), .latch(latch), .pulse(pulse), .buttons(buttons),
    .data(data), .frame_done(frame_done), .active(active), .poll_count(poll_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // one clock: advance the pad model by the pin history it would see, then compare
  task automatic tick();
    logic lr, lf, pr, ev, cnt;
    @(posedge clk);
    if (rst) begin
      m_st = M_IDLE; m_k = 0; m_q = 0; m_polls = 0; m_frame = 16'hFFFF; m_done = 0; lh = '0; ph = '0;
    end else begin
      lh = {lh[2:0], latch};
      ph = {ph[2:0], pulse};
      lr = lh[2] & ~lh[3];
      lf = ~lh[2] & lh[3];
      pr = ph[2] & ~ph[3];
      ev = (lh[2] ^ lh[3]) | (ph[2] ^ ph[3]);
      cnt = m_st == M_SHIFT || m_st == M_DONE;
      m_done = 0;
      if (m_st == M_SHIFT && pr && !lr) stream[m_k] = prev_data;
      if (lr || (m_st == M_IDLE && lh[2])) begin
        m_st = M_LOAD; m_k = 0; m_frame = {ID, ~buttons};
      end else if (m_st == M_LOAD) begin
        m_frame = {ID, ~buttons};
        if (lf) m_st = M_SHIFT;
      end else if (cnt && !ev && m_q == T - 1) m_st = M_IDLE;
      else if (m_st == M_SHIFT && pr) begin
        m_k++;
        if (m_k == 16) begin m_st = M_DONE; m_done = 1; m_polls++; end
      end
      m_q = (ev || !cnt) ? 0 : (m_q == T - 1 ? m_q : m_q + 1);
    end
    #1;
    check("data", data, m_st == M_IDLE ? 1'b1 : m_st == M_DONE ? 1'b0 : m_frame[m_k]);
    check("active", active, m_st == M_LOAD || m_st == M_SHIFT);
    check("frame_done", frame_done, m_done);
    check("poll_count", poll_count, m_polls & 255);
    fd_cnt += int'(frame_done);
    prev_data = data;
  endtask

  function automatic int w(input bit r);
    return r ? int'($urandom_range(1, 4)) : 3;
  endfunction

  task automatic frame(input logic [11:0] b, input int np, input int chg, input logic [11:0] nb, input bit r);
    buttons = b;
    latch = 1;
    repeat (r ? w(1) : 4) tick();
    latch = 0;
    repeat (3) tick();
    for (int i = 0; i < np; i++) begin
      if (i == chg) buttons = nb;
      pulse = 1;
      repeat (w(r)) tick();
      pulse = 0;
      repeat (w(r)) tick();
    end
    repeat (3) tick();
  endtask

  initial begin
    repeat (5) tick();
    check("rst_data", data, 1'b1);
    check("rst_active", active, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_poll", poll_count, 8'd0);
    rst = 0;
    repeat (2) tick();
    check("post_rst_data", data, 1'b1);
    check("post_rst_active", active, 1'b0);
    fd_cnt = 0;
    frame(12'h0A5, 16, -1, 12'h000, 0);
    check("full_stream", stream, 16'hFF5A);
    check("full_done_data", data, 1'b0);
    check("full_fd_pulses", fd_cnt, 1);
    check("full_poll", poll_count, 8'd1);
    nframes = 1;
    frame(12'h000, 16, 3, 12'hFFF, 0);
    check("snap_stream", stream, 16'hFFFF);
    check("snap_data", data, 1'b0);
    check("snap_poll", poll_count, 8'd2);
    nframes = 2;
    fd_cnt = 0;
    frame(12'h3C6, 7, -1, 12'h000, 0);
    buttons = 12'h001;
    latch = 1;
    repeat (3) tick();
    check("abort_active", active, 1'b1);
    check("abort_data", data, 1'b0);
    check("abort_poll", poll_count, 8'd2);
    check("abort_no_fd", fd_cnt, 0);
    frame(12'h5A3, 16, -1, 12'h000, 0);
    check("after_abort_stream", stream, 16'hFA5C);
    check("after_abort_poll", poll_count, 8'd3);
    nframes = 3;
    frame(12'h123, 3, -1, 12'h000, 0);
    repeat (96) tick();
    check("timeout_still_active", active, 1'b1);
    tick();
    check("timeout_active", active, 1'b0);
    check("timeout_data", data, 1'b1);
    while (nframes < 256) begin
      int np;
      np = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : 16;
      frame(12'($urandom()), np, int'($urandom_range(0, 16)), 12'($urandom()), 1);
      if (np == 16) nframes++;
    end
    check("wrap_poll", poll_count, 8'd0);
    frame(12'h0F0, 5, -1, 12'h000, 0);
    check("pre_rst_active", active, 1'b1);
    #2 rst = 1;
    #1;
    check("async_rst_data", data, 1'b1);
    check("async_rst_active", active, 1'b0);
    repeat (2) tick();
    rst = 0;
    pulse = 1;
    repeat (4) tick();
    pulse = 0;
    repeat (4) tick();
    check("after_rst_data", data, 1'b1);
    check("after_rst_active", active, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
